// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serial pattern transmitter feeding sequence detectors on j
//
// Loads a WIDTH-bit pattern word through a valid/ready handshake and shifts it
// out MSB-first on j, one bit per clock. The word is sent rep_in+1 times, with
// GAP idle cycles between repetitions.
//
// Ports:
//   clock       system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   data_in     pattern word to transmit (MSB first)
//   rep_in      extra repetitions (0 = send once)
//   load_valid  load request for data_in/rep_in
//   load_ready  block can accept a load this cycle
//   j           registered serial bit stream
//   busy        transfer in progress
//   done        one-cycle pulse at the end of a transfer
module serial_pattern_tx #(
    parameter int   WIDTH    = 4,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0,
    parameter int   REP_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [REP_W-1:0] rep_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             j,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              j_q, j_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            j_q       <= IDLE_BIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            j_q       <= j_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic. The shift register rotates rather than shifts, so after
    // WIDTH bits it holds the original word again and serves as its own reload copy.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    state_d   = S_SHIFT;
                    shreg_d   = data_in;
                    rep_cnt_d = rep_in;
                    bit_cnt_d = LAST_BIT;
                end
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = LAST_BIT;
                    if (rep_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        rep_cnt_d = rep_cnt_q - 1'b1;
                        if (GAP != 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = GAP_LAST;
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the upcoming state.
    always_comb begin
        j_d     = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : IDLE_BIT;
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_q == S_SHIFT) && (state_d == S_IDLE);
    end

    assign j          = j_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit side of the single-bit serial stream consumed by the team's sequence detectors. Those detectors take `clock`, `j`, `reset` and produce `w`.
- The block accepts a parallel pattern word through a valid/ready handshake.
- It shifts the word out MSB-first on `j`, one bit per clock, repeating it a programmable number of times with optional idle gaps.
- It drives detector benches and on-chip self-test paths in place of hand-written `j` stimulus.

Parameters:
- WIDTH, 4, pattern word width in bits (2..32).
- GAP, 0, number of idle cycles inserted between repetitions (0..15).
- IDLE_BIT, 0, value driven on `j` when no pattern bit is being sent.
- REP_W, 4, width of the repeat-count input.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  pattern word to transmit, MSB sent first.
- rep_in  input  REP_W  extra repetitions; 0 means send the word once.
- load_valid  input  1  request to load `data_in`/`rep_in`.
- load_ready  output  1  block can accept a load this cycle.
- j  output  1  serial bit stream (registered).
- busy  output  1  a transfer is in progress.
- done  output  1  one-cycle pulse at the end of a transfer.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-high.
  - While `reset`=1, independent of `clock`: state=IDLE, `j`=IDLE_BIT, `load_ready`=1, `busy`=0, `done`=0, and the shift register and all counters are cleared.
  - Reset asserted mid-transfer aborts immediately. No `done` is generated, and the aborted word is discarded.
- States: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE:
  - `load_ready`=1, `busy`=0, `j`=IDLE_BIT.
  - A load is accepted at a rising edge with `load_valid`=1: capture `data_in` into the shift register, `rep_in` into rep_cnt, set bit_cnt=WIDTH-1, move to SHIFT.
  - Latency is one cycle: in the cycle after the accepting edge, `j`=data_in[WIDTH-1], `busy`=1, `load_ready`=0.
- SHIFT:
  - Each edge advances one bit, so `j` carries bits WIDTH-1 down to 0 over exactly WIDTH consecutive cycles.
  - At the edge ending bit 0:
    - If rep_cnt=0, go to IDLE: `j`=IDLE_BIT, `done`=1 for exactly that one cycle, `busy`=0, `load_ready`=1.
    - If rep_cnt>0 and GAP=0, decrement rep_cnt, reload the word from the held copy, and `j`=bit WIDTH-1 in the very next cycle (no bubble).
    - If rep_cnt>0 and GAP>0, decrement rep_cnt, go to GAP, `j`=IDLE_BIT.
- GAP:
  - `j`=IDLE_BIT and `busy`=1 for exactly GAP cycles, then SHIFT with `j`=bit WIDTH-1.
- Transfer length: total `busy` cycles = (rep_in+1)*WIDTH + rep_in*GAP.
- Handshake edge cases:
  - `load_valid` while `load_ready`=0 is ignored, with no effect and no queuing.
  - `data_in`/`rep_in` changes after acceptance do not affect the transfer in flight.
  - Back-to-back loads: a load in the `done` cycle is accepted (ready=1 there). `j` shows one IDLE_BIT cycle between words.
- Wrap-around:
  - rep_in at maximum (2^REP_W-1) gives 2^REP_W copies; the counter must not underflow.
  - bit_cnt and gap_cnt reload on each repetition.
- `done` and `load_ready` are never both low in IDLE; `done`=1 implies `load_ready`=1.

Test Plan:
- Reset, then with WIDTH=4, GAP=0 load data_in=4'b1001, rep_in=0 -> j=1,0,0,1 on the 4 cycles after acceptance, then j=0 with done=1 for one cycle; busy high exactly 4 cycles.
- WIDTH=4, GAP=2, data 4'b1001, rep_in=2 -> j=1001 00 1001 00 1001, then idle; busy high 16 cycles; a single done pulse at the end.
- Assert load_valid with a new word during busy -> ignored; the in-flight stream is unchanged and load_ready stays 0 until done.
- Load 4'b1001 with load_valid held high across the done cycle and a second word 4'b0110 presented -> second word accepted at the done edge; j=1001 0 0110.
- Assert reset asynchronously (between clock edges) two bits into the 4'b1001 transfer -> j=IDLE_BIT, busy=0, load_ready=1 immediately; no done; the next load transmits cleanly.
- Connect j to both sequence detectors, send 4'b1001 with rep_in=3, GAP=1 -> detector w outputs assert once per completed pattern (4 times) and agree with each other.
